// File: rtl/register_file_4x24.sv
// Four-entry register file with one write port and two independently enabled, registered read ports.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to a colliding read.
module register_file_4x24 #(
  parameter int WIDTH = 24,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [1:0]       raddr_a,
  input  logic             re_b,
  input  logic [1:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic [3:0]       written
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd_a_next;
  logic [WIDTH-1:0] rd_b_next;

  always_comb begin
    rd_a_next = regs[raddr_a];
    rd_b_next = regs[raddr_b];
`ifdef REGFILE_BYPASS_EN
    // a write landing on the same index this edge wins over the stored value
    if (we && (waddr == raddr_a)) rd_a_next = wdata;
    if (we && (waddr == raddr_b)) rd_b_next = wdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      written <= '0;
    end else if (we) begin
      regs[waddr]    <= wdata;
      written[waddr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (re_a) rdata_a <= rd_a_next;
      if (re_b) rdata_b <= rd_b_next;
    end
  end

endmodule

// File: tb/tb_register_file_4x24.sv
// Directed self-checking bench for register_file_4x24; collision expectation follows REGFILE_BYPASS_EN.
module tb_register_file_4x24;

  localparam int WIDTH = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             we;
  logic [1:0]       waddr;
  logic [WIDTH-1:0] wdata;
  logic             re_a;
  logic [1:0]       raddr_a;
  logic             re_b;
  logic [1:0]       raddr_b;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic [3:0]       written;

  int checks   = 0;
  int failures = 0;

  register_file_4x24 #(.WIDTH(WIDTH), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .written(written)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; re_a = 1'b0; re_b = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] coll_exp;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;
    step(); step();
    chk("reset_rdata_a", 32'(rdata_a), 32'h0);
    chk("reset_rdata_b", 32'(rdata_b), 32'h0);
    chk("reset_written", 32'(written), 32'h0);

    // fill all registers, then reset and confirm everything cleared
    rst_n = 1'b1;
    we = 1'b1;
    waddr = 2'd0; wdata = 24'h3C1F07; step();
    waddr = 2'd1; wdata = 24'hA5005A; step();
    waddr = 2'd2; wdata = 24'h00FF00; step();
    waddr = 2'd3; wdata = 24'hDEAD01; step();
    we = 1'b0;
    chk("fill_written", 32'(written), 32'hF);
    re_a = 1'b1; raddr_a = 2'd1; re_b = 1'b1; raddr_b = 2'd3; step();
    chk("fill_rd_a_r1", 32'(rdata_a), 32'hA5005A);
    chk("fill_rd_b_r3", 32'(rdata_b), 32'hDEAD01);
    idle();
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    chk("rst2_rdata_a", 32'(rdata_a), 32'h0);
    chk("rst2_rdata_b", 32'(rdata_b), 32'h0);
    chk("rst2_written", 32'(written), 32'h0);
    re_a = 1'b1; re_b = 1'b1;
    raddr_a = 2'd0; raddr_b = 2'd3; step();
    chk("rst2_r0", 32'(rdata_a), 32'h0);
    chk("rst2_r3", 32'(rdata_b), 32'h0);
    raddr_a = 2'd1; raddr_b = 2'd2; step();
    chk("rst2_r1", 32'(rdata_a), 32'h0);
    chk("rst2_r2", 32'(rdata_b), 32'h0);
    idle();

    // write then read r2
    we = 1'b1; waddr = 2'd2; wdata = 24'hABCDEF; step();
    we = 1'b0;
    chk("wr_written", 32'(written), 32'h4);
    re_a = 1'b1; raddr_a = 2'd2; step();
    chk("wr_rd_a_r2", 32'(rdata_a), 32'hABCDEF);
    idle();

    // dual-port read of r1 and r3
    we = 1'b1; waddr = 2'd1; wdata = 24'h000001; step();
    waddr = 2'd3; wdata = 24'hFFFFFF; step();
    we = 1'b0;
    chk("dp_written", 32'(written), 32'hE);
    re_a = 1'b1; raddr_a = 2'd1; re_b = 1'b1; raddr_b = 2'd3; step();
    chk("dp_rd_a", 32'(rdata_a), 32'h000001);
    chk("dp_rd_b", 32'(rdata_b), 32'hFFFFFF);

    // hold while disabled, even as the source register changes
    idle();
    we = 1'b1; waddr = 2'd1; wdata = 24'h123456; step();
    we = 1'b0; step();
    chk("hold_rd_a", 32'(rdata_a), 32'h000001);
    chk("hold_rd_b", 32'(rdata_b), 32'hFFFFFF);
    re_a = 1'b1; raddr_a = 2'd1; step();
    chk("hold_reread", 32'(rdata_a), 32'h123456);

    // both ports on the same index
    re_a = 1'b1; raddr_a = 2'd2; re_b = 1'b1; raddr_b = 2'd2; step();
    chk("same_idx_a", 32'(rdata_a), 32'hABCDEF);
    chk("same_idx_b", 32'(rdata_b), 32'hABCDEF);
    idle();

    // same-cycle write/read collision on r0, both ports
    we = 1'b1; waddr = 2'd0; wdata = 24'h111111; step();
    re_a = 1'b1; raddr_a = 2'd0; re_b = 1'b1; raddr_b = 2'd0;
    wdata = 24'h222222; step();
    we = 1'b0;
`ifdef REGFILE_BYPASS_EN
    coll_exp = 24'h222222;
`else
    coll_exp = 24'h111111;
`endif
    chk("coll_rd_a", 32'(rdata_a), 32'(coll_exp));
    chk("coll_rd_b", 32'(rdata_b), 32'(coll_exp));
    raddr_b = 2'd3; step();
    chk("coll_after_a", 32'(rdata_a), 32'h222222);
    chk("coll_other_b", 32'(rdata_b), 32'hFFFFFF);

    // reset asserted mid-cycle must not disturb outputs before the edge
    rst_n = 1'b0; #2;
    chk("async_rd_a", 32'(rdata_a), 32'h222222);
    chk("async_written", 32'(written), 32'hF);
    // write offered during reset is dropped
    idle();
    we = 1'b1; waddr = 2'd3; wdata = 24'h5A5A5A; step();
    chk("rstpri_written", 32'(written), 32'h0);
    chk("rstpri_rd_a", 32'(rdata_a), 32'h0);
    rst_n = 1'b1; we = 1'b0;
    re_a = 1'b1; raddr_a = 2'd3; step();
    chk("rstpri_r3", 32'(rdata_a), 32'h0);

    // first cycle after reset accepts a write and read normally
    we = 1'b1; waddr = 2'd3; wdata = 24'h0F0F0F; re_a = 1'b0; step();
    we = 1'b0; re_a = 1'b1; step();
    chk("post_rst_r3", 32'(rdata_a), 32'h0F0F0F);
    chk("post_rst_written", 32'(written), 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_4x24.md
REGISTER_FILE_4X24 -- requirements
Module: register_file_4x24

Interface
REQ-001 Parameter WIDTH, default 24, data width of each register and of all data ports.
REQ-002 Parameter NREGS, default 4, register count; fixed at 4 (2-bit addresses), other values unsupported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 we  input  1  write enable.
REQ-006 waddr  input  2  write register index.
REQ-007 wdata  input  WIDTH  write data.
REQ-008 re_a  input  1  read enable, port A.
REQ-009 raddr_a  input  2  read register index, port A.
REQ-010 re_b  input  1  read enable, port B.
REQ-011 raddr_b  input  2  read register index, port B.
REQ-012 rdata_a  output  WIDTH  registered read data, port A; drives downstream 4:1 operand-select muxes bit-sliced.
REQ-013 rdata_b  output  WIDTH  registered read data, port B.
REQ-014 written  output  4  per-register flag, bit i set once register i has been written since reset.

Function
REQ-015 Storage SHALL be 4 registers r0..r3 of WIDTH bits; no hardwired-zero register.
REQ-016 On rising edge with we=1, r[waddr] SHALL take wdata; all other registers SHALL hold.
REQ-017 On rising edge with re_a=1, rdata_a SHALL take the value of r[raddr_a] (1-cycle read latency); with re_a=0, rdata_a SHALL hold its previous value.
REQ-018 Port B SHALL behave identically to port A using re_b/raddr_b/rdata_b, independently of port A.
REQ-019 Both ports reading the same index in the same cycle SHALL both return the same value.
REQ-020 Same-cycle write and read of the same index: behaviour SHALL be governed by REQ-027/REQ-028.
REQ-021 written[waddr] SHALL be set on every edge with we=1 and SHALL never clear except by reset.
REQ-022 Write data SHALL be stored unmodified; no arithmetic, truncation or sign extension.

Reset
REQ-023 On rising edge with rst_n=0, r0..r3 SHALL become 0, rdata_a and rdata_b SHALL become 0, written SHALL become 4'b0000.
REQ-024 Reset SHALL take priority over any simultaneous write or read; a write presented in a reset cycle SHALL be discarded.
REQ-025 Reset asserted mid-sequence SHALL take effect on the next rising edge only; outputs SHALL not change asynchronously.
REQ-026 First cycle after rst_n returns high SHALL accept writes and reads normally.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined, a read enabled in the same cycle as we=1 to the same index SHALL return wdata (write-through forwarding), per port.
REQ-028 Without REGFILE_BYPASS_EN, that read SHALL return the old register contents; the new value SHALL be visible to reads on the following edge.

Verification
REQ-029 Reset: rst_n=0 one edge after random writes -> rdata_a=rdata_b=0, written=0000, reads of r0..r3 return 0.
REQ-030 Write/read: write 24'hABCDEF to r2, next cycle re_a=1 raddr_a=2 -> rdata_a=24'hABCDEF one edge later; written=0100.
REQ-031 Dual port: r1=24'h000001, r3=24'hFFFFFF, read A=1 B=3 same cycle -> rdata_a=24'h000001, rdata_b=24'hFFFFFF.
REQ-032 Hold: re_a=0 while r[raddr_a] is rewritten to 24'h123456 -> rdata_a keeps prior value.
REQ-033 Collision: r0=24'h111111, same cycle we=1 waddr=0 wdata=24'h222222 with re_a=1 raddr_a=0 -> rdata_a=24'h222222 with REGFILE_BYPASS_EN, 24'h111111 without.
REQ-034 Reset priority: rst_n=0 with we=1 waddr=3 wdata=24'h5A5A5A -> r3=0, written[3]=0 after the edge.
